exu_wb_arbiter: RTL and testbench
=================================

# exu_wb_arbiter

Arbitrates the single integer register-file write port among the single-cycle ALU path and three multi-cycle result sources: muldiv, memory/load, and CSR. The arbiter sits between the execute units and the regfile. It replaces the combinational priority mux with a registered, handshaked scheduler. ALU results normally win, but a starvation counter guarantees forward progress for the multi-cycle units, which round-robin among themselves.

## Interface
Parameters:
- STARVE_LIMIT, default 4: number of consecutive cycles a multi-cycle requester may be denied before the ALU is stalled. Legal range is 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- alu_we_i  in  1  ALU has a result this cycle
- alu_waddr_i  in  5  ALU destination register
- alu_wdata_i  in  32  ALU result
- alu_stall_o  out  1  ALU result not accepted; the pipeline holds the ALU inputs stable
- muldiv_valid_i / mem_valid_i / csr_valid_i  in  1 each  requester has a result pending
- muldiv_waddr_i / mem_waddr_i / csr_waddr_i  in  5 each  destination register
- muldiv_wdata_i / mem_wdata_i / csr_wdata_i  in  32 each  result data
- muldiv_ready_o / mem_ready_o / csr_ready_o  out  1 each  result accepted this cycle
- reg_we_o  out  1  regfile write enable (registered)
- reg_waddr_o  out  5  regfile write address (registered)
- reg_wdata_o  out  32  regfile write data (registered)

## Operation
- Requester handshake: a transfer occurs when valid=1 and ready=1. Once valid is raised, it and its waddr/wdata are held until ready. ready_o is combinational from the current-cycle state and valids.
- At most one grant is made per cycle: either the ALU or exactly one requester.
- State:
  - rr_ptr, 2 bits, values 0=muldiv, 1=mem, 2=csr; value 3 is never reached.
  - starve_cnt, 4 bits.
  - starve, 1 bit, set when starve_cnt == STARVE_LIMIT.
- Grant rules:
  - If alu_we_i=1 and starve=0, grant the ALU. alu_stall_o=0 and all ready_o=0.
  - Otherwise, grant the first valid requester scanning from rr_ptr in the order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - If alu_we_i=1 and a requester is granted, alu_stall_o=1.
  - If starve=1 but no requester is valid, which cannot occur in a legal sequence, grant the ALU.
  - alu_stall_o is never 1 when alu_we_i=0.
- rr_ptr updates only on a requester grant: it becomes (granted index + 1) mod 3.
- starve_cnt:
  - Clears to 0 on any requester grant, or when no requester is valid.
  - Otherwise, when at least one requester is valid and the ALU is granted, it increments, saturating at STARVE_LIMIT.
- Writeback register:
  - On any grant, reg_waddr_o and reg_wdata_o load the winner's address and data.
  - reg_we_o loads 1 only if the winner's waddr != 0; a write to x0 is accepted but suppressed.
  - With no grant, reg_we_o loads 0 and addr/data hold their values.
- The ALU carries no valid/ready beyond alu_stall_o. A stalled ALU result is re-presented unchanged the next cycle.

## Timing
- Reset (async assert) values: reg_we_o=0, reg_waddr_o=0, reg_wdata_o=0, rr_ptr=0, starve_cnt=0.
- Reset deassertion is synchronized externally. The first grant can occur on the first rising edge after rst_n=1.
- Latency: a grant in cycle N produces the regfile write visible on the outputs in cycle N+1, one register stage. Throughput is one write per cycle.
- Requester ready_o is asserted in the same cycle as the grant. The requester may drop or change valid in cycle N+1.
- Starvation bound: with the ALU busy every cycle, a pending requester is granted no later than STARVE_LIMIT+1 cycles after it raises valid. This bound applies while other requesters are not also pending; with k requesters pending, the bound is k·(STARVE_LIMIT+1).
- Reset mid-operation: outputs clear immediately, and any in-flight writeback is dropped. Requesters must re-present after reset.

## Test plan
- ALU only: alu_we_i=1, waddr=5, wdata=0x1234 for 3 cycles, no requesters. Expect alu_stall_o=0 throughout and reg_we_o=1 with waddr 5 / wdata 0x1234 one cycle later, each cycle.
- Round-robin: muldiv, mem, and csr all valid with waddr 1, 2, 3 from reset, ALU idle. Expect grants in the order muldiv, mem, csr on consecutive cycles, with writes to x1, x2, x3 at cycles +1, +2, +3, and rr_ptr=0 afterwards.
- Starvation with STARVE_LIMIT=4: ALU is continuously valid, mem_valid_i rises at cycle 0. Expect ALU grants in cycles 0–3, then mem_ready_o=1 and alu_stall_o=1 in cycle 4. The ALU result is written in cycle 6, and starve_cnt returns to 0.
- x0 suppression: csr_valid_i with waddr=0, wdata=0xFFFFFFFF. Expect csr_ready_o=1 and reg_we_o=0 on the next cycle.
- Async reset mid-stream: assert rst_n=0 between edges while reg_we_o=1. Expect all outputs to go to 0 immediately with no clock edge, and a rr_ptr=0 grant order after release.

Source files
------------

// File: rtl/exu_wb_arbiter.sv
// exu_wb_arbiter
//
// Schedules the single integer register-file write port. The single-cycle ALU path
// normally wins, and three multi-cycle sources (muldiv, mem, csr) share the port
// round-robin. A starvation counter stalls the ALU once a pending requester has been
// denied STARVE_LIMIT cycles in a row, so the multi-cycle units always make progress.
// The winner is captured in a single writeback register stage.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   alu_we_i/waddr_i/wdata_i        ALU result for this cycle
//   alu_stall_o                     ALU result not accepted; re-presented next cycle
//   <src>_valid_i/waddr_i/wdata_i   multi-cycle result, held until ready
//   <src>_ready_o                   result accepted this cycle (combinational)
//   reg_we_o/waddr_o/wdata_o        registered regfile write port
//
// STARVE_LIMIT legal range is 1..15.

module exu_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        alu_we_i,
  input  logic [4:0]  alu_waddr_i,
  input  logic [31:0] alu_wdata_i,
  output logic        alu_stall_o,

  input  logic        muldiv_valid_i,
  input  logic [4:0]  muldiv_waddr_i,
  input  logic [31:0] muldiv_wdata_i,
  output logic        muldiv_ready_o,

  input  logic        mem_valid_i,
  input  logic [4:0]  mem_waddr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_ready_o,

  input  logic        csr_valid_i,
  input  logic [4:0]  csr_waddr_i,
  input  logic [31:0] csr_wdata_i,
  output logic        csr_ready_o,

  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o
);

  localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);

  // Round-robin pointer: 0 = muldiv, 1 = mem, 2 = csr.
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        reg_we_q, reg_we_d;
  logic [4:0]  reg_waddr_q, reg_waddr_d;
  logic [31:0] reg_wdata_q, reg_wdata_d;

  logic [2:0]  req_valid;
  logic        any_valid;
  logic        starve;
  logic [1:0]  rr_eff;
  logic [2:0]  req_rot;
  logic [1:0]  rot_off;
  logic [2:0]  gnt_sum;
  logic [1:0]  gnt_idx;
  logic        req_take;
  logic        alu_gnt;
  logic [2:0]  req_gnt;
  logic [4:0]  req_waddr;
  logic [31:0] req_wdata;
  logic [4:0]  win_waddr;
  logic [31:0] win_wdata;

  assign req_valid = {csr_valid_i, mem_valid_i, muldiv_valid_i};
  assign any_valid = |req_valid;
  assign starve    = (starve_cnt_q == StarveLimit);

  // The encoding 3 is unreachable; fold it onto muldiv so the scan stays defined.
  assign rr_eff = (rr_ptr_q == 2'd3) ? 2'd0 : rr_ptr_q;

  // Rotate the valids so bit 0 is the requester the pointer currently favours.
  always_comb begin
    req_rot = req_valid;
    unique case (rr_eff)
      2'd1:    req_rot = {req_valid[0], req_valid[2], req_valid[1]};
      2'd2:    req_rot = {req_valid[1], req_valid[0], req_valid[2]};
      default: req_rot = req_valid;
    endcase
  end

  always_comb begin
    rot_off = 2'd0;
    if (req_rot[0]) begin
      rot_off = 2'd0;
    end else if (req_rot[1]) begin
      rot_off = 2'd1;
    end else if (req_rot[2]) begin
      rot_off = 2'd2;
    end
  end

  // Map the rotated offset back to an absolute requester index (mod 3).
  assign gnt_sum = {1'b0, rr_eff} + {1'b0, rot_off};
  assign gnt_idx = (gnt_sum >= 3'd3) ? 2'(gnt_sum - 3'd3) : gnt_sum[1:0];

  // A requester wins whenever one is valid, unless the ALU has a result and nobody
  // is starving. When starving with no requester valid the ALU still goes through.
  assign req_take = any_valid & ~(alu_we_i & ~starve);
  assign alu_gnt  = alu_we_i & ~req_take;
  assign req_gnt  = req_take ? (3'b001 << gnt_idx) : 3'b000;

  assign muldiv_ready_o = req_gnt[0];
  assign mem_ready_o    = req_gnt[1];
  assign csr_ready_o    = req_gnt[2];
  assign alu_stall_o    = alu_we_i & req_take;

  always_comb begin
    req_waddr = muldiv_waddr_i;
    req_wdata = muldiv_wdata_i;
    case (gnt_idx)
      2'd0: begin
        req_waddr = muldiv_waddr_i;
        req_wdata = muldiv_wdata_i;
      end
      2'd1: begin
        req_waddr = mem_waddr_i;
        req_wdata = mem_wdata_i;
      end
      default: begin
        req_waddr = csr_waddr_i;
        req_wdata = csr_wdata_i;
      end
    endcase
  end

  assign win_waddr = alu_gnt ? alu_waddr_i : req_waddr;
  assign win_wdata = alu_gnt ? alu_wdata_i : req_wdata;

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    starve_cnt_d = starve_cnt_q;
    reg_we_d     = 1'b0;
    reg_waddr_d  = reg_waddr_q;
    reg_wdata_d  = reg_wdata_q;

    if (req_take) begin
      rr_ptr_d = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
    end

    if (req_take || !any_valid) begin
      starve_cnt_d = 4'd0;
    end else if (alu_gnt && !starve) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    // Writes to x0 are accepted from the source but never reach the regfile.
    if (alu_gnt || req_take) begin
      reg_we_d    = (win_waddr != 5'd0);
      reg_waddr_d = win_waddr;
      reg_wdata_d = win_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= 2'd0;
      starve_cnt_q <= 4'd0;
      reg_we_q     <= 1'b0;
      reg_waddr_q  <= 5'd0;
      reg_wdata_q  <= 32'd0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      reg_we_q     <= reg_we_d;
      reg_waddr_q  <= reg_waddr_d;
      reg_wdata_q  <= reg_wdata_d;
    end
  end

  assign reg_we_o    = reg_we_q;
  assign reg_waddr_o = reg_waddr_q;
  assign reg_wdata_o = reg_wdata_q;

endmodule

// File: tb/tb_exu_wb_arbiter.sv
module tb_exu_wb_arbiter;

  localparam int Limit = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        alu_we = 1'b0;
  logic [4:0]  alu_waddr = '0;
  logic [31:0] alu_wdata = '0;
  logic [2:0]  v = '0;
  logic [4:0]  ra [3];
  logic [31:0] rd [3];

  wire         stall;
  wire [2:0]   rdy;
  wire         we_o;
  wire [4:0]   waddr_o;
  wire [31:0]  wdata_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exu_wb_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_we_i       (alu_we),
    .alu_waddr_i    (alu_waddr),
    .alu_wdata_i    (alu_wdata),
    .alu_stall_o    (stall),
    .muldiv_valid_i (v[0]),
    .muldiv_waddr_i (ra[0]),
    .muldiv_wdata_i (rd[0]),
    .muldiv_ready_o (rdy[0]),
    .mem_valid_i    (v[1]),
    .mem_waddr_i    (ra[1]),
    .mem_wdata_i    (rd[1]),
    .mem_ready_o    (rdy[1]),
    .csr_valid_i    (v[2]),
    .csr_waddr_i    (ra[2]),
    .csr_wdata_i    (rd[2]),
    .csr_ready_o    (rdy[2]),
    .reg_we_o       (we_o),
    .reg_waddr_o    (waddr_o),
    .reg_wdata_o    (wdata_o)
  );

  // Reference model: integer pointer and counter, winner chosen by a modular scan.
  // pick: -1 no grant, 0..2 requester, 3 ALU.
  int          m_rr, m_cnt;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          pick_now;
  logic [4:0]  win_a;
  logic [31:0] win_d;

  function automatic int pick(input logic alu, input logic [2:0] vv, input int rr,
                              input int cnt);
    if (alu && cnt != Limit) return 3;
    for (int k = 0; k < 3; k++) begin
      if (vv[(rr + k) % 3]) return (rr + k) % 3;
    end
    return alu ? 3 : -1;
  endfunction

  always_comb begin
    pick_now = pick(alu_we, v, m_rr, m_cnt);
    win_a = '0;
    win_d = '0;
    if (pick_now == 3) begin
      win_a = alu_waddr;
      win_d = alu_wdata;
    end else if (pick_now >= 0) begin
      win_a = ra[pick_now];
      win_d = rd[pick_now];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rr <= 0; m_cnt <= 0; m_we <= 1'b0; m_addr <= '0; m_data <= '0;
    end else begin
      if (pick_now >= 0) begin
        m_we <= (win_a != 5'd0); m_addr <= win_a; m_data <= win_d;
      end else begin
        m_we <= 1'b0;
      end
      if (pick_now >= 0 && pick_now < 3) begin
        m_rr  <= (pick_now + 1) % 3;
        m_cnt <= 0;
      end else if (v == 3'b000) begin
        m_cnt <= 0;
      end else if (m_cnt < Limit) begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        alu_we;
    logic [4:0]  alu_a;
    logic [31:0] alu_d;
    logic [2:0]  v;
    logic [4:0]  csr_a;
    logic [31:0] csr_d;
    logic [3:0]  exp_sr;   // {stall, csr, mem, muldiv ready}
    logic        exp_we;
    logic [4:0]  exp_a;
    logic [31:0] exp_d;
  } vec_t;

  function automatic vec_t mk(input logic aw, input logic [4:0] aa, input logic [31:0] ad,
                              input logic [2:0] vv, input logic [4:0] ca,
                              input logic [31:0] cd, input logic [3:0] sr, input logic ew,
                              input logic [4:0] ea, input logic [31:0] ed);
    vec_t r;
    r.alu_we = aw; r.alu_a = aa; r.alu_d = ad; r.v = vv; r.csr_a = ca; r.csr_d = cd;
    r.exp_sr = sr; r.exp_we = ew; r.exp_a = ea; r.exp_d = ed;
    return r;
  endfunction

  vec_t tbl [12];
  int   last_pick;
  int   wait_c [3];

  initial begin
    // ALU-only, round-robin, x0 suppression, ALU-beats-requester without starvation.
    tbl[0]  = mk(1, 5, 32'h1234, 3'b000, 3, 32'h33, 4'b0000, 0, 0, 32'h0);
    tbl[1]  = mk(1, 5, 32'h1234, 3'b000, 3, 32'h33, 4'b0000, 1, 5, 32'h1234);
    tbl[2]  = mk(1, 5, 32'h1234, 3'b000, 3, 32'h33, 4'b0000, 1, 5, 32'h1234);
    tbl[3]  = mk(0, 0, 32'h0,    3'b111, 3, 32'h33, 4'b0001, 1, 5, 32'h1234);
    tbl[4]  = mk(0, 0, 32'h0,    3'b110, 3, 32'h33, 4'b0010, 1, 1, 32'h11);
    tbl[5]  = mk(0, 0, 32'h0,    3'b100, 3, 32'h33, 4'b0100, 1, 2, 32'h22);
    tbl[6]  = mk(0, 0, 32'h0,    3'b000, 3, 32'h33, 4'b0000, 1, 3, 32'h33);
    tbl[7]  = mk(0, 0, 32'h0,    3'b100, 0, 32'hFFFFFFFF, 4'b0100, 0, 3, 32'h33);
    tbl[8]  = mk(0, 0, 32'h0,    3'b000, 0, 32'hFFFFFFFF, 4'b0000, 0, 0, 32'hFFFFFFFF);
    tbl[9]  = mk(1, 6, 32'h66,   3'b001, 0, 32'h0, 4'b0000, 0, 0, 32'hFFFFFFFF);
    tbl[10] = mk(0, 0, 32'h0,    3'b001, 0, 32'h0, 4'b0001, 1, 6, 32'h66);
    tbl[11] = mk(0, 0, 32'h0,    3'b000, 0, 32'h0, 4'b0000, 1, 1, 32'h11);

    for (int i = 0; i < 3; i++) begin
      ra[i] = '0;
      rd[i] = '0;
      wait_c[i] = 0;
    end

    #2 rst_n = 1'b0;
    #6 check("reset_outputs", {we_o, waddr_o, wdata_o}, 64'h0);
    #4 rst_n = 1'b1;
    tick();

    ra[0] = 5'd1; rd[0] = 32'h11;
    ra[1] = 5'd2; rd[1] = 32'h22;
    for (int i = 0; i < 12; i++) begin
      alu_we = tbl[i].alu_we; alu_waddr = tbl[i].alu_a; alu_wdata = tbl[i].alu_d;
      v = tbl[i].v; ra[2] = tbl[i].csr_a; rd[2] = tbl[i].csr_d;
      @(negedge clk);
      check($sformatf("vec%0d_grant", i), {60'h0, stall, rdy}, {60'h0, tbl[i].exp_sr});
      check($sformatf("vec%0d_wb", i), {we_o, waddr_o, wdata_o},
            {tbl[i].exp_we, tbl[i].exp_a, tbl[i].exp_d});
      tick();
    end

    // Starvation: ALU busy, mem waits STARVE_LIMIT cycles, then stalls the ALU.
    alu_we = 1'b1; alu_waddr = 5'd7; alu_wdata = 32'hA5A5;
    v = 3'b010; ra[1] = 5'd2; rd[1] = 32'h22;
    for (int c = 0; c < Limit; c++) begin
      @(negedge clk);
      check($sformatf("starve_alu_win%0d", c), {stall, rdy}, 4'b0000);
      tick();
    end
    @(negedge clk);
    check("starve_mem_grant", {stall, rdy}, 4'b1010);
    tick();
    v = 3'b000;
    @(negedge clk);
    check("starve_release", {stall, rdy}, 4'b0000);
    check("starve_mem_write", {we_o, waddr_o, wdata_o}, {1'b1, 5'd2, 32'h22});
    tick();
    check("starve_alu_write", {we_o, waddr_o, wdata_o}, {1'b1, 5'd7, 32'hA5A5});
    v = 3'b010;
    for (int c = 0; c < Limit; c++) begin
      @(negedge clk);
      check($sformatf("starve_again_alu%0d", c), {stall, rdy}, 4'b0000);
      tick();
    end
    @(negedge clk);
    check("starve_cnt_cleared", {stall, rdy}, 4'b1010);
    tick();

    // Asynchronous reset while a write is on the outputs (rr_ptr is 2 here).
    v = 3'b000; alu_waddr = 5'd8; alu_wdata = 32'h88;
    tick();
    check("pre_reset_write", {we_o, waddr_o, wdata_o}, {1'b1, 5'd8, 32'h88});
    #2 rst_n = 1'b0;
    #1 check("async_reset_clear", {we_o, waddr_o, wdata_o}, 64'h0);
    alu_we = 1'b0; v = 3'b111;
    ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd3;
    rd[0] = 32'h11; rd[1] = 32'h22; rd[2] = 32'h33;
    #2 rst_n = 1'b1;
    #2 check("post_reset_muldiv", {stall, rdy}, 4'b0001);
    tick();
    v = 3'b110;
    @(negedge clk);
    check("post_reset_mem", {stall, rdy}, 4'b0010);
    check("post_reset_wb_x1", {we_o, waddr_o, wdata_o}, {1'b1, 5'd1, 32'h11});
    tick();
    v = 3'b100;
    @(negedge clk);
    check("post_reset_csr", {stall, rdy}, 4'b0100);
    tick();
    v = 3'b000;
    tick();

    // Randomized legal traffic against the model.
    last_pick = -1;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (v[i] && last_pick == i) begin
          v[i] = 1'($urandom_range(1, 0));
          ra[i] = ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom);
          rd[i] = $urandom;
          wait_c[i] = 0;
        end else if (!v[i]) begin
          if ($urandom_range(2, 0) == 0) begin
            v[i] = 1'b1;
            ra[i] = ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom);
            rd[i] = $urandom;
            wait_c[i] = 0;
          end
        end else begin
          wait_c[i]++;
        end
      end
      if (!(alu_we && last_pick != 3)) begin
        alu_we = ($urandom_range(3, 0) != 0);
        alu_waddr = 5'($urandom);
        alu_wdata = $urandom;
      end
      @(negedge clk);
      check("rand_grant", {stall, rdy},
            {(alu_we && pick_now >= 0 && pick_now < 3), pick_now == 2, pick_now == 1,
             pick_now == 0});
      check("rand_wb", {we_o, waddr_o, wdata_o}, {m_we, m_addr, m_data});
      if (pick_now >= 0 && pick_now < 3) begin
        check("rand_starve_bound", {63'h0, wait_c[pick_now] > 3 * (Limit + 1)}, 64'h0);
      end
      last_pick = pick_now;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
